// File: rtl/weighted_rr_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package weighted_rr_pkg;

    localparam int unsigned MaxChannels = 64;
    localparam int unsigned MaxWeightW  = 16;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        GRANT
    } state_t;

    // A programmed weight of zero still grants one cycle.
    function automatic logic [MaxWeightW-1:0] w_eff(input logic [MaxWeightW-1:0] w);
        return (w == '0) ? MaxWeightW'(1) : w;
    endfunction

    // Rotate the low n bits of v left by one position.
    function automatic logic [MaxChannels-1:0] rotate_left(input logic [MaxChannels-1:0] v,
                                                           input int unsigned n);
        logic [MaxChannels-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MaxChannels; i++) begin
            if (i < n) begin
                r[(i + 1) % n] = v[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Circular priority pick: first requester after ptr, wrapping round to ptr itself.
module rr_pick
    import weighted_rr_pkg::*;
#(
    parameter int unsigned CHANNELS = 8
) (
    input  logic [CHANNELS-1:0] ptr,
    input  logic [CHANNELS-1:0] r,
    output logic [CHANNELS-1:0] winner
);

    logic [MaxChannels-1:0] cand;

    always_comb begin
        winner = '0;
        cand   = MaxChannels'(ptr);
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            cand = rotate_left(cand, CHANNELS);
            if (winner == '0 && (cand[CHANNELS-1:0] & r) != '0) begin
                winner = cand[CHANNELS-1:0];
            end
        end
    end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter: holds each grant for up to its channel weight in cycles,
// hands over without a bubble and registers a prediction of the next winner.
module weighted_rr_arbiter
    import weighted_rr_pkg::*;
#(
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned WEIGHT_W = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS-1:0]          req,
    input  logic [CHANNELS*WEIGHT_W-1:0] weight,
    input  logic                         weight_load,
    output logic [CHANNELS-1:0]          gnt,
    output logic                         gnt_valid,
    output logic                         gnt_last,
    output logic [CHANNELS-1:0]          next_gnt
);

    localparam logic [CHANNELS-1:0] PtrRst = {1'b1, {(CHANNELS - 1){1'b0}}};
    localparam logic [CHANNELS*WEIGHT_W-1:0] WeightRst = {CHANNELS{WEIGHT_W'(1)}};

    state_t                       state_q, state_d;
    logic [WEIGHT_W-1:0]          credit_q, credit_d;
    logic [CHANNELS-1:0]          ptr_q, ptr_d;
    logic [CHANNELS-1:0]          gnt_q, gnt_d;
    logic [CHANNELS-1:0]          next_gnt_q, next_gnt_d;
    logic [CHANNELS*WEIGHT_W-1:0] weight_q;
    logic                         gnt_valid_q, gnt_last_q;
    logic [CHANNELS-1:0]          winner, pred_ptr;
    logic [WEIGHT_W-1:0]          win_weight, win_credit;
    logic                         hold;

    rr_pick #(.CHANNELS(CHANNELS)) u_pick_gnt (
        .ptr    (ptr_q),
        .r      (req),
        .winner (winner)
    );

    // Prediction scans from the grant being loaded, or from ptr when nothing is granted.
    assign pred_ptr = (gnt_d != '0) ? gnt_d : ptr_d;

    rr_pick #(.CHANNELS(CHANNELS)) u_pick_next (
        .ptr    (pred_ptr),
        .r      (req),
        .winner (next_gnt_d)
    );

    always_comb begin
        win_weight = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (winner[i]) begin
                win_weight = win_weight | weight_q[i*WEIGHT_W +: WEIGHT_W];
            end
        end
        win_credit = WEIGHT_W'(w_eff(MaxWeightW'(win_weight)));
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        hold     = 1'b0;
        case (state_q)
            INIT: begin
                state_d  = IDLE;
                gnt_d    = '0;
                credit_d = '0;
            end
            IDLE, GRANT: begin
                hold = (state_q == GRANT) && ((req & gnt_q) != '0) &&
                       (credit_q > WEIGHT_W'(1));
                if (hold) begin
                    credit_d = credit_q - WEIGHT_W'(1);
                end else begin
                    gnt_d = winner;
                    if (winner != '0) begin
                        ptr_d    = winner;
                        credit_d = win_credit;
                        state_d  = GRANT;
                    end else begin
                        credit_d = '0;
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                state_d  = INIT;
                gnt_d    = '0;
                credit_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT;
            credit_q    <= '0;
            ptr_q       <= PtrRst;
            weight_q    <= WeightRst;
            gnt_q       <= '0;
            next_gnt_q  <= '0;
            gnt_valid_q <= 1'b0;
            gnt_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            next_gnt_q  <= next_gnt_d;
            gnt_valid_q <= |gnt_d;
            gnt_last_q  <= (state_d == GRANT) && (credit_d == WEIGHT_W'(1));
            if (weight_load) begin
                weight_q <= weight;
            end
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_last  = gnt_last_q;
    assign next_gnt  = next_gnt_q;

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Directed bench for weighted_rr_arbiter with hand-computed grant sequences.
module tb_weighted_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [7:0]  req;
    logic [31:0] weight;
    logic        weight_load;
    logic [7:0]  gnt;
    logic        gnt_valid;
    logic        gnt_last;
    logic [7:0]  next_gnt;

    int n_checks;
    int n_errors;

    weighted_rr_arbiter #(.CHANNELS(8), .WEIGHT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .weight      (weight),
        .weight_load (weight_load),
        .gnt         (gnt),
        .gnt_valid   (gnt_valid),
        .gnt_last    (gnt_last),
        .next_gnt    (next_gnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input int ch, input logic [3:0] val);
        weight[ch*4 +: 4] = val;
    endtask

    // Weighted-share expectations, starting from ptr = ch1 with weights 3/1/2.
    logic [7:0] share_gnt  [9] = '{8'h04, 8'h04, 8'h01, 8'h01, 8'h01, 8'h02, 8'h04, 8'h04, 8'h01};
    logic       share_last [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] share_next [9] = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h04, 8'h01, 8'h01, 8'h02};

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b1;
        req         = '0;
        weight      = {8{4'h1}};
        weight_load = 1'b0;

        // Reset and INIT cycle
        #12;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_valid", 32'(gnt_valid), 32'h0);
        check("rst_next", 32'(next_gnt), 32'h0);
        rst = 1'b0;
        req = 8'hFF;
        step();
        check("init_gnt", 32'(gnt), 32'h0);
        check("init_valid", 32'(gnt_valid), 32'h0);
        step();
        check("first_gnt", 32'(gnt), 32'h01);
        check("first_valid", 32'(gnt_valid), 32'h1);
        check("first_next", 32'(next_gnt), 32'h02);
        check("first_last", 32'(gnt_last), 32'h1);
        step();
        check("handover_gnt", 32'(gnt), 32'h02);
        check("handover_next", 32'(next_gnt), 32'h04);

        // Weighted share: ch0=3, ch1=1, ch2=2
        req = 8'h00;
        weight = {8{4'h1}};
        set_w(0, 4'd3);
        set_w(2, 4'd2);
        weight_load = 1'b1;
        step();
        weight_load = 1'b0;
        check("to_idle_gnt", 32'(gnt), 32'h0);
        req = 8'h07;
        for (int k = 0; k < 9; k++) begin
            step();
            check($sformatf("share_gnt[%0d]", k), 32'(gnt), 32'(share_gnt[k]));
            check($sformatf("share_last[%0d]", k), 32'(gnt_last), 32'(share_last[k]));
            check($sformatf("share_next[%0d]", k), 32'(next_gnt), 32'(share_next[k]));
        end

        // Zero weight, sole requester: regrant every cycle
        req = 8'h00;
        weight = {8{4'h1}};
        set_w(5, 4'd0);
        weight_load = 1'b1;
        step();
        weight_load = 1'b0;
        check("zw_idle", 32'(gnt), 32'h0);
        req = 8'h20;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("zw_gnt[%0d]", k), 32'(gnt), 32'h20);
            check($sformatf("zw_last[%0d]", k), 32'(gnt_last), 32'h1);
            check($sformatf("zw_next[%0d]", k), 32'(next_gnt), 32'h20);
        end

        // Early release: ch0 weight 5, ch3 weight 2
        req = 8'h00;
        weight = {8{4'h1}};
        set_w(0, 4'd5);
        set_w(3, 4'd2);
        weight_load = 1'b1;
        step();
        weight_load = 1'b0;
        check("er_idle", 32'(gnt), 32'h0);
        req = 8'h09;
        step();
        check("er_gnt0", 32'(gnt), 32'h01);
        check("er_next0", 32'(next_gnt), 32'h08);
        check("er_last0", 32'(gnt_last), 32'h0);
        step();
        check("er_gnt1", 32'(gnt), 32'h01);
        req = 8'h08;
        step();
        check("er_gnt2", 32'(gnt), 32'h08);
        check("er_last2", 32'(gnt_last), 32'h0);
        check("er_next2", 32'(next_gnt), 32'h08);
        step();
        check("er_gnt3", 32'(gnt), 32'h08);
        check("er_last3", 32'(gnt_last), 32'h1);
        step();
        check("er_last4", 32'(gnt_last), 32'h0);

        // Weight reload mid-grant: current grant keeps old credit
        req = 8'h00;
        weight = {8{4'h1}};
        set_w(1, 4'd2);
        weight_load = 1'b1;
        step();
        weight_load = 1'b0;
        check("wr_idle", 32'(gnt), 32'h0);
        req = 8'h02;
        step();
        check("wr_gnt0", 32'(gnt), 32'h02);
        check("wr_last0", 32'(gnt_last), 32'h0);
        set_w(1, 4'd7);
        weight_load = 1'b1;
        step();
        weight_load = 1'b0;
        check("wr_gnt1", 32'(gnt), 32'h02);
        check("wr_last1", 32'(gnt_last), 32'h1);
        for (int k = 0; k < 7; k++) begin
            step();
            check($sformatf("wr7_gnt[%0d]", k), 32'(gnt), 32'h02);
            check($sformatf("wr7_last[%0d]", k), 32'(gnt_last), (k == 6) ? 32'h1 : 32'h0);
        end

        // Requests vanish: handover to idle
        req = 8'h00;
        step();
        check("idle_gnt", 32'(gnt), 32'h0);
        check("idle_valid", 32'(gnt_valid), 32'h0);
        check("idle_last", 32'(gnt_last), 32'h0);
        check("idle_next", 32'(next_gnt), 32'h0);
        step();
        check("idle_hold", 32'(gnt), 32'h0);
        req = 8'h06;
        step();
        check("resume_gnt", 32'(gnt), 32'h04);

        // Asynchronous reset mid-grant
        #2;
        rst = 1'b1;
        #1;
        check("async_gnt", 32'(gnt), 32'h0);
        check("async_valid", 32'(gnt_valid), 32'h0);
        check("async_next", 32'(next_gnt), 32'h0);
        rst = 1'b0;
        req = 8'hFF;
        step();
        check("rst2_init", 32'(gnt), 32'h0);
        step();
        check("rst2_gnt", 32'(gnt), 32'h01);
        check("rst2_last", 32'(gnt_last), 32'h1);
        check("rst2_next", 32'(next_gnt), 32'h02);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/weighted_rr_arbiter.md
# weighted_rr_arbiter

Parametrised weighted round-robin arbiter for the shared-resource front end. It grants one of CHANNELS requesters at a time and holds each grant for up to that channel's programmed weight in cycles. It hands over without a bubble cycle and publishes a registered next-grant prediction. It is the successor of the team's fixed 8-channel, unweighted next-grant precalculator.

## Interface
- CHANNELS, 8: number of requesters, ≥2
- WEIGHT_W, 4: width of each per-channel weight and of the credit counter
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  CHANNELS  request vector, level-sensitive
- weight  in  CHANNELS*WEIGHT_W  packed weights; channel i occupies bits [i*WEIGHT_W +: WEIGHT_W]
- weight_load  in  1  latches `weight` into the internal weight register weight_q
- gnt  out  CHANNELS  registered grant, one-hot or zero
- gnt_valid  out  1  registered, equals |gnt
- gnt_last  out  1  registered, high when the current cycle is the final credit of the current grant
- next_gnt  out  CHANNELS  registered prediction of the channel that wins the next handover; one-hot or zero

## Operation
- Reset values:
  - gnt, next_gnt, gnt_valid, gnt_last = 0
  - credit = 0
  - weight_q: all fields = 1
  - ptr (one-hot last-granted) = bit CHANNELS-1, so channel 0 has first priority
- Effective weight: w_eff(i) = weight_q[i], except 0 counts as 1. The maximum is 2^WEIGHT_W−1.
- pick(ptr, r): first set bit of r scanning circularly from ptr+1 up to and including ptr itself. It returns 0 when r == 0.
- State machine (state_t):
  - INIT: entered on reset. On the first clk edge after rst deasserts, go to IDLE; no grant is issued in this cycle.
  - IDLE: gnt = 0. If req ≠ 0, set gnt = pick(ptr, req), load credit = w_eff(winner), set ptr = winner, and go to GRANT. Otherwise stay in IDLE.
  - GRANT, current channel i:
    - If req[i] = 1 and credit > 1: decrement credit and hold gnt.
    - Otherwise (credit = 1, or req[i] dropped) hand over: gnt = pick(ptr, req), credit reloads for the new winner, ptr updates. This includes regranting i when i is the only requester.
    - If req = 0 at handover: gnt = 0 and go to IDLE.
  - Illegal state encoding goes to INIT.
- gnt_last = 1 when the registered state is GRANT and credit = 1.
- next_gnt = pick(gnt_new, req) registered alongside gnt, where gnt_new is the grant being loaded and req is the same sampled req. When gnt_new = 0, next_gnt = pick(ptr_new, req).
- weight_load updates weight_q at the edge. The new values affect only credit reloads from the next edge onward; the credit of the grant in progress is unchanged. If weight_load coincides with a reload, the reload uses the old weight_q.
- The credit counter never underflows. Reload always happens before credit would reach 0.

## Timing
- Request to grant: req sampled at edge N produces gnt at edge N (visible in cycle N+1). The first grant after reset deassertion comes no earlier than the second edge.
- Hold: a channel with weight w and continuous req keeps gnt for exactly w consecutive cycles.
- Handover has zero bubble: gnt switches directly i→j at one edge when another requester is pending.
- req[i] dropping during its grant releases the grant at the next edge. Remaining credit is discarded.
- gnt_valid, gnt_last and next_gnt are aligned with gnt (same register stage).
- rst asserted mid-grant clears all outputs immediately (asynchronous). weight_q returns to all 1s.

## Structure
- Package weighted_rr_pkg:
  - state_t enum {INIT, IDLE, GRANT}
  - function w_eff (zero maps to one)
  - function rotate_left for one-hot vectors
- Sub-module rr_pick (combinational, parameter CHANNELS): inputs ptr and r, output one-hot winner. It is instantiated twice, once for the grant and once for the next_gnt prediction.
- Top-level contents: state register, credit counter, ptr, weight_q, output registers.

## Test plan
- Reset/INIT: rst pulse, with req = 8'hFF held from deassertion. The first edge gives gnt = 0; the second edge gives gnt = 8'h01, gnt_valid = 1, next_gnt = 8'h02.
- Weighted share: weights ch0 = 3, ch1 = 1, ch2 = 2, with req = 8'h07 held. The gnt sequence repeats 01,01,01,02,04,04, and gnt_last is high on the 3rd, 4th and 6th cycles.
- Zero weight and sole requester: weight ch5 = 0, only req[5] = 1. gnt = 8'h20 is held every cycle and gnt_last = 1 every cycle (regrant each cycle).
- Early release: ch0 weight 5 with req = 8'h09. Drop req[0] in the 2nd grant cycle. The next edge gives gnt = 8'h08 with credit = w_eff(3).
- Weight reload timing: weight_load with ch1 = 7 asserted during ch1's grant at weight 2. The current grant lasts 2 cycles and the next ch1 grant lasts 7.
- Idle and mid-reset: req → 0 during a grant ends in gnt = 0 and IDLE after the handover edge. A later rst asserted mid-GRANT gives gnt = 0 asynchronously, and the next grant again starts at channel 0 priority.
